// File: rtl/oam_dma_arbiter.sv
// rtl/oam_dma_arbiter.sv - sprite DMA engine that borrows the system bus from the CPU
module oam_dma_arbiter #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_rw,
  output logic        cpu_ready,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_data_out,
  output logic        mem_rw,
  input  logic [7:0]  mem_data_in,
  output logic        dma_active,
  output logic        dma_done
);

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        parity;
  logic [7:0]  page;
  logic [7:0]  idx;
  logic [7:0]  data_buf;
  logic        trigger;

  assign dma_active = (state != IDLE);

  // State register plus the free-running parity that decides whether an ALIGN cycle is needed
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state  <= IDLE;
      parity <= 1'b0;
    end else begin
      state  <= state_next;
      parity <= ~parity;
    end
  end

  // Transfer datapath: source page, byte index (wraps within the page) and the read-to-write buffer
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      page     <= 8'h00;
      idx      <= 8'h00;
      data_buf <= 8'h00;
    end else begin
      if (trigger) begin
        page <= cpu_data_out;
        idx  <= 8'h00;
      end
      if (state == READ) begin
        data_buf <= mem_data_in;
      end
      if (state == WRITE) begin
        idx <= idx + 8'd1;
      end
    end
  end

  // Next-state and bus mux: CPU owns the bus in IDLE, the DMA owns it everywhere else
  always_comb begin
    state_next   = state;
    trigger      = 1'b0;
    cpu_ready    = 1'b0;
    dma_done     = 1'b0;
    mem_addr     = cpu_addr;
    mem_data_out = cpu_data_out;
    mem_rw       = cpu_rw;
    case (state)
      IDLE: begin
        cpu_ready = 1'b1;
        if (!cpu_rw && (cpu_addr == DMA_REG_ADDR)) begin
          trigger    = 1'b1;
          state_next = HALT;
        end
      end
      HALT: begin
        // Dummy read of whatever the stalled CPU is presenting
        mem_rw       = 1'b1;
        mem_data_out = 8'h00;
        state_next   = parity ? READ : ALIGN;
      end
      ALIGN: begin
        mem_rw       = 1'b1;
        mem_data_out = 8'h00;
        state_next   = READ;
      end
      READ: begin
        mem_addr     = {page, idx};
        mem_rw       = 1'b1;
        mem_data_out = 8'h00;
        state_next   = WRITE;
      end
      WRITE: begin
        mem_addr     = OAM_DATA_ADDR;
        mem_rw       = 1'b0;
        mem_data_out = data_buf;
        if (idx == 8'hFF) begin
          dma_done   = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = READ;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// tb/tb_oam_dma_arbiter.sv - self-checking bench for oam_dma_arbiter
module tb_oam_dma_arbiter;

  logic        clock = 1'b0;
  logic        nreset = 1'b0;
  logic [15:0] cpu_addr = 16'h8123;
  logic [7:0]  cpu_data_out = 8'h5A;
  logic        cpu_rw = 1'b1;
  logic        cpu_ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data_out;
  logic        mem_rw;
  logic [7:0]  mem_data_in;
  logic        dma_active;
  logic        dma_done;

  always #5 clock = ~clock;

  // Memory returns the inverted low address byte
  assign mem_data_in = ~mem_addr[7:0];

  oam_dma_arbiter dut (
    .clock        (clock),
    .nreset       (nreset),
    .cpu_addr     (cpu_addr),
    .cpu_data_out (cpu_data_out),
    .cpu_rw       (cpu_rw),
    .cpu_ready    (cpu_ready),
    .mem_addr     (mem_addr),
    .mem_data_out (mem_data_out),
    .mem_rw       (mem_rw),
    .mem_data_in  (mem_data_in),
    .dma_active   (dma_active),
    .dma_done     (dma_done)
  );

  // Expected bus schedule: kind 0 = dummy read of cpu_addr, 1 = page read, 2 = OAM write
  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        done;
  } ent_t;

  ent_t        q[$];
  logic        m_par = 1'b0;
  int          checks = 0;
  int          errors = 0;

  int          dma_writes = 0;
  int          dma_dones = 0;
  int          run = 0;
  int          last_run = 0;
  int          ends = 0;
  int          active_cycles = 0;
  logic        prev_active = 1'b0;
  logic [15:0] prev_addr = 16'h0;
  logic [15:0] first_read = 16'h0;
  logic [15:0] last_read = 16'h0;
  logic [7:0]  first_wdata = 8'h0;
  logic [7:0]  last_wdata = 8'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic build(input logic [7:0] page, input logic par);
    ent_t e;
    logic [7:0] k;
    e = {2'd0, 16'h0000, 8'h00, 1'b0};
    q.push_back(e);
    if (par) q.push_back(e);
    for (int i = 0; i < 256; i++) begin
      k = i[7:0];
      q.push_back({2'd1, {page, k}, 8'h00, 1'b0});
      q.push_back({2'd2, 16'h2004, ~k, (i == 255)});
    end
  endtask

  task automatic compare_loop();
    logic [31:0] exp;
    logic [31:0] act;
    ent_t e;
    forever begin
      @(posedge clock);
      if (!nreset) begin
        q.delete();
        m_par = 1'b0;
      end else begin
        if (q.size() > 0) void'(q.pop_front());
        else if (!cpu_rw && cpu_addr == 16'h4014) build(cpu_data_out, m_par);
        m_par = ~m_par;
      end
      @(negedge clock);
      if (!nreset || q.size() == 0) begin
        exp = {4'b0, 1'b1, 1'b0, 1'b0, cpu_rw, cpu_addr, cpu_data_out};
      end else begin
        e = q[0];
        case (e.kind)
          2'd0:    exp = {4'b0, 1'b0, 1'b1, 1'b0, 1'b1, cpu_addr, 8'h00};
          2'd1:    exp = {4'b0, 1'b0, 1'b1, 1'b0, 1'b1, e.addr, 8'h00};
          default: exp = {4'b0, 1'b0, 1'b1, e.done, 1'b0, e.addr, e.data};
        endcase
      end
      act = {4'b0, cpu_ready, dma_active, dma_done, mem_rw, mem_addr, mem_data_out};
      check("bus", act, exp);
      if (dma_active && !prev_active) begin
        dma_writes = 0;
        dma_dones  = 0;
      end
      if (dma_active) active_cycles++;
      if (dma_active && !mem_rw) begin
        if (dma_writes == 0) begin
          first_read  = prev_addr;
          first_wdata = mem_data_out;
        end
        last_read  = prev_addr;
        last_wdata = mem_data_out;
        dma_writes++;
      end
      if (dma_done) dma_dones++;
      if (!cpu_ready) run++;
      else if (run > 0) begin
        last_run = run;
        run = 0;
        ends++;
      end
      prev_active = dma_active;
      prev_addr   = mem_addr;
    end
  endtask

  task automatic idle_bus();
    cpu_addr     = 16'h8123;
    cpu_rw       = 1'b1;
    cpu_data_out = 8'h5A;
  endtask

  task automatic trig(input logic [7:0] page, input logic par);
    @(posedge clock); #1;
    for (int n = 0; n < 4 && m_par != par; n++) begin
      @(posedge clock); #1;
    end
    cpu_addr     = 16'h4014;
    cpu_rw       = 1'b0;
    cpu_data_out = page;
    @(posedge clock); #1;
    idle_bus();
  endtask

  task automatic wait_end();
    int start;
    int n;
    start = ends;
    n = 0;
    while (ends == start && n < 1200) begin
      @(negedge clock); #2;
      n++;
    end
    check("dma_end_seen", 32'(ends != start), 32'd1);
  endtask

  task automatic stimulus();
    int a;
    int n;
    logic found;
    idle_bus();
    repeat (3) @(posedge clock);
    #1;
    check("rst_ready", 32'(cpu_ready), 32'd1);
    check("rst_active", 32'(dma_active), 32'd0);
    check("rst_mirror", 32'(mem_addr), 32'(cpu_addr));
    nreset = 1'b1;

    // Parity 0 trigger on page 02
    trig(8'h02, 1'b0);
    wait_end();
    check("p0_low_cycles", 32'(last_run), 32'd513);
    check("p0_writes", 32'(dma_writes), 32'd256);
    check("p0_dones", 32'(dma_dones), 32'd1);
    check("p0_first_read", 32'(first_read), 32'h0200);
    check("p0_last_read", 32'(last_read), 32'h02FF);
    check("p0_first_wdata", 32'(first_wdata), 32'hFF);
    check("p0_last_wdata", 32'(last_wdata), 32'h00);

    // Parity 1 trigger needs an ALIGN cycle
    trig(8'h02, 1'b1);
    wait_end();
    check("p1_low_cycles", 32'(last_run), 32'd514);
    check("p1_writes", 32'(dma_writes), 32'd256);
    check("p1_first_read", 32'(first_read), 32'h0200);

    // Top page stays inside FF00..FFFF
    trig(8'hFF, 1'b0);
    wait_end();
    check("ff_first_read", 32'(first_read), 32'hFF00);
    check("ff_last_read", 32'(last_read), 32'hFFFF);
    check("ff_writes", 32'(dma_writes), 32'd256);

    // Near-miss accesses must not start a DMA
    a = active_cycles;
    @(posedge clock); #1;
    cpu_addr = 16'h4014; cpu_rw = 1'b1; cpu_data_out = 8'h02;
    @(posedge clock); #1;
    cpu_addr = 16'h4013; cpu_rw = 1'b0; cpu_data_out = 8'h07;
    @(posedge clock); #1;
    cpu_addr = 16'h4015; cpu_rw = 1'b0; cpu_data_out = 8'h08;
    @(posedge clock); #1;
    idle_bus();
    repeat (4) @(posedge clock);
    #1;
    check("no_trigger", 32'(active_cycles), 32'(a));

    // Reset during the READ of idx 40 aborts the DMA
    trig(8'h01, 1'b0);
    found = 1'b0;
    for (n = 0; n < 600 && !found; n++) begin
      @(negedge clock); #2;
      if (dma_active && mem_rw && mem_addr == 16'h0140) found = 1'b1;
    end
    check("abort_point_seen", 32'(found), 32'd1);
    check("abort_writes", 32'(dma_writes), 32'd64);
    nreset = 1'b0;
    #1;
    check("abort_ready", 32'(cpu_ready), 32'd1);
    check("abort_active", 32'(dma_active), 32'd0);
    check("abort_mirror", 32'(mem_addr), 32'(cpu_addr));
    @(negedge clock); #2;
    nreset = 1'b1;
    trig(8'h03, 1'b0);
    wait_end();
    check("restart_first_read", 32'(first_read), 32'h0300);
    check("restart_writes", 32'(dma_writes), 32'd256);

    // Trigger presented in the cycle right after dma_done
    trig(8'h04, 1'b0);
    found = 1'b0;
    for (n = 0; n < 700 && !found; n++) begin
      @(negedge clock); #2;
      if (dma_done) found = 1'b1;
    end
    check("b2b_done_seen", 32'(found), 32'd1);
    cpu_addr = 16'h4014; cpu_rw = 1'b0; cpu_data_out = 8'h06;
    @(posedge clock); #1;
    @(posedge clock); #1;
    idle_bus();
    check("b2b_first_low", 32'(last_run), 32'd513);
    wait_end();
    check("b2b_second_low", 32'(last_run), 32'd513);
    check("b2b_writes", 32'(dma_writes), 32'd256);
    check("b2b_first_read", 32'(first_read), 32'h0600);
    check("b2b_dones", 32'(dma_dones), 32'd1);
    repeat (3) @(posedge clock);
  endtask

  initial begin
    fork
      compare_loop();
      stimulus();
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/oam_dma_arbiter.md
OAM_DMA_ARBITER -- requirements
Module: oam_dma_arbiter

Interface
REQ-001 SHALL have parameter DMA_REG_ADDR, default 16'h4014, the CPU write address that starts a DMA.
REQ-002 SHALL have parameter OAM_DATA_ADDR, default 16'h2004, the fixed destination address of every DMA write.
REQ-003 SHALL have clock  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have nreset  input  1  reset; asynchronous, active-low.
REQ-005 SHALL have cpu_addr  input  16  CPU address bus.
REQ-006 SHALL have cpu_data_out  input  8  CPU write data.
REQ-007 SHALL have cpu_rw  input  1  CPU direction (0=write, 1=read).
REQ-008 SHALL have cpu_ready  output  1  1 = the CPU may advance this cycle; 0 = the CPU holds all state.
REQ-009 SHALL have mem_addr  output  16  arbitrated system address bus.
REQ-010 SHALL have mem_data_out  output  8  arbitrated write data.
REQ-011 SHALL have mem_rw  output  1  arbitrated direction (0=write, 1=read).
REQ-012 SHALL have mem_data_in  input  8  memory read data; valid in the same cycle as mem_addr.
REQ-013 SHALL have dma_active  output  1  high whenever the state is not IDLE.
REQ-014 SHALL have dma_done  output  1  single-cycle pulse during the final DMA write.

Function
REQ-015 SHALL use states IDLE, HALT, ALIGN, READ and WRITE.
REQ-016 SHALL keep a parity bit that toggles on every clock, independent of state.
REQ-017 SHALL trigger when state=IDLE, cpu_rw=0 and cpu_addr=DMA_REG_ADDR; on that edge it latches page<=cpu_data_out and idx<=0, and moves to HALT.
REQ-018 SHALL NOT trigger on a read of DMA_REG_ADDR, on a write to any other address, or while the state is not IDLE.
REQ-019 In IDLE, SHALL drive mem_addr/mem_data_out/mem_rw combinationally equal to cpu_addr/cpu_data_out/cpu_rw, with cpu_ready=1.
REQ-020 In every state other than IDLE, SHALL drive cpu_ready=0 and hold the CPU bus off mem_*.
REQ-021 In HALT, SHALL drive mem_rw=1 and mem_addr=cpu_addr (a dummy read); next state is READ if parity=1, else ALIGN.
REQ-022 In ALIGN, SHALL drive the same dummy read as HALT; next state is READ.
REQ-023 As a consequence of REQ-021 and REQ-022, every READ SHALL occur with parity=0.
REQ-024 In READ, SHALL drive mem_addr={page,idx} and mem_rw=1, latch buf<=mem_data_in, and go to WRITE.
REQ-025 In WRITE, SHALL drive mem_addr=OAM_DATA_ADDR, mem_rw=0 and mem_data_out=buf, then increment idx (8-bit).
REQ-026 In WRITE, if idx=8'hFF, SHALL assert dma_done and go to IDLE; otherwise go to READ.
REQ-027 SHALL NOT let idx carry into page: page FF reads FF00..FFFF.
REQ-028 SHALL hold cpu_ready=0 for 513 cycles when parity=0 in the trigger cycle and 514 cycles when parity=1, with 256 reads and 256 writes strictly alternating.
REQ-029 SHALL return cpu_ready=1 in the cycle after the final WRITE; a trigger in that cycle starts a new DMA.
REQ-030 SHALL drive mem_data_out=8'h00 in every non-IDLE state except WRITE.

Reset
REQ-031 While nreset=0, SHALL force immediately: state=IDLE, parity=0, page=0, idx=0, buf=0, cpu_ready=1, dma_active=0, dma_done=0, mem_* following cpu_*.
REQ-032 Reset asserted mid-DMA SHALL abort the DMA with no further writes; the next trigger restarts at idx=0.

Verification
REQ-033 Write 8'h02 to 4014 with parity=0 -> cpu_ready low exactly 513 cycles; reads 0200..02FF alternate with writes to 2004; dma_done pulses once.
REQ-034 Same write with parity=1 -> one ALIGN cycle, 514 cycles low, first READ at parity=0.
REQ-035 Memory returns ~addr[7:0] -> the 256 writes carry data FF,FE,..,00 in order; page FF reads FF00..FFFF with no wrap into page 00.
REQ-036 Read of 4014, and writes to 4013/4015 -> no trigger; mem_* mirror cpu_* every cycle.
REQ-037 nreset pulsed low during the READ of idx 8'h40 -> immediate IDLE with cpu_ready=1; a new write of 8'h03 -> first read at 0300.
REQ-038 Trigger in the cycle immediately after dma_done -> second DMA starts with correct alignment and a full 256-byte count.
